serial_add_seq: RTL and testbench

//  Bit-serial WIDTH-bit adder sequencer: accepts two operands plus carry-in over valid/ready,

---
 rtl/serial_add_seq_pkg.sv | 13 +
 rtl/serial_add_seq_if.sv | 27 ++
 rtl/serial_add_seq_addbit.sv | 17 +
 rtl/serial_add_seq.sv | 102 ++++++++++
 tb/tb_serial_add_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_seq_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and the
// widest operand the sequencer is built for.
package serial_add_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand request / result handshake bundle for serial_add_seq.
// The master drives requests and accepts results; the slave is the sequencer.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_ci, out_ready,
        input  in_ready, out_valid, out_sum, out_co, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci, out_ready,
        output in_ready, out_valid, out_sum, out_co, busy
    );

endinterface

// File: rtl/serial_add_seq_addbit.sv
// Gate-level 1-bit full adder cell; purely combinational, sampled by the
// sequencer only at the clock edge.
module addbit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign sum     = halfSum ^ ci;
    assign co      = (a & b) | (halfSum & ci);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: shifts operands LSB-first through one addbit cell,
// keeps the carry in a register between bits and reassembles the sum MSB-in.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cell_sum;
    logic               cell_co;
    logic               last_bit;

    addbit u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .ci  (carry_q),
        .sum (cell_sum),
        .co  (cell_co)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The sum enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB;
    // written as shift/or so it also holds for WIDTH == 1.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && bus.in_valid) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            sum_d   = '0;
            carry_d = bus.in_ci;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = (sum_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
            carry_d = cell_co;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // The result registers are the shift registers themselves, so they keep
    // their last values in IDLE until the next request is accepted.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.out_sum   = sum_q;
        bus.out_co    = carry_q;
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed vectors at WIDTH 8, 1 and 64,
// backpressure, mid-operation reset and a randomised handshake run at WIDTH 8.
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    serial_add_seq_if #(.WIDTH(8))  bus8  ();
    serial_add_seq_if #(.WIDTH(1))  bus1  ();
    serial_add_seq_if #(.WIDTH(64)) bus64 ();

    serial_add_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_seq #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
    serial_add_seq #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    task automatic checkOutput(input string tag, input logic [64:0] observed,
                               input logic [64:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one WIDTH-8 operation from IDLE; optionally holds DONE and keeps
    // in_valid high with junk operands while the sequencer is busy.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                 input logic [7:0] expSum, input logic expCo,
                                 input int holdCycles, input bit noisy);
        int edges;
        checkOutput("in_ready_idle", bus8.in_ready, 1);
        bus8.in_a      = a;
        bus8.in_b      = b;
        bus8.in_ci     = ci;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b0;
        stepCycle();
        checkOutput("busy_shift", bus8.busy, 1);
        checkOutput("in_ready_shift", bus8.in_ready, 0);
        bus8.in_valid = noisy;
        if (noisy) begin
            bus8.in_a  = 8'($urandom);
            bus8.in_b  = 8'($urandom);
            bus8.in_ci = 1'($urandom_range(0, 1));
        end
        edges = 0;
        while (!bus8.out_valid && edges < 40) begin
            stepCycle();
            edges++;
        end
        checkOutput("latency8", 65'(edges), 65'd8);
        checkOutput("sum8", bus8.out_sum, expSum);
        checkOutput("co8", bus8.out_co, expCo);
        for (int i = 0; i < holdCycles; i++) begin
            stepCycle();
            checkOutput("hold_valid", bus8.out_valid, 1);
            checkOutput("hold_sum", bus8.out_sum, expSum);
            checkOutput("hold_co", bus8.out_co, expCo);
            checkOutput("hold_in_ready", bus8.in_ready, 0);
        end
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        stepCycle();
        bus8.out_ready = 1'b0;
        checkOutput("valid_drop", bus8.out_valid, 0);
        checkOutput("in_ready_back", bus8.in_ready, 1);
        checkOutput("busy_idle", bus8.busy, 0);
        checkOutput("sum_kept_idle", bus8.out_sum, expSum);
    endtask

    task automatic runW1(input logic a, input logic b, input logic ci,
                         input logic expSum, input logic expCo);
        int edges;
        bus1.in_a = a; bus1.in_b = b; bus1.in_ci = ci;
        bus1.in_valid = 1'b1;
        stepCycle();
        bus1.in_valid = 1'b0;
        edges = 0;
        while (!bus1.out_valid && edges < 10) begin
            stepCycle();
            edges++;
        end
        checkOutput("latency1", 65'(edges), 65'd1);
        checkOutput("sum1", bus1.out_sum, expSum);
        checkOutput("co1", bus1.out_co, expCo);
        bus1.out_ready = 1'b1;
        stepCycle();
        bus1.out_ready = 1'b0;
        checkOutput("in_ready1", bus1.in_ready, 1);
    endtask

    task automatic runW64(input logic [63:0] a, input logic [63:0] b, input logic ci,
                          input logic [63:0] expSum, input logic expCo);
        int edges;
        bus64.in_a = a; bus64.in_b = b; bus64.in_ci = ci;
        bus64.in_valid = 1'b1;
        stepCycle();
        bus64.in_valid = 1'b0;
        edges = 0;
        while (!bus64.out_valid && edges < 100) begin
            stepCycle();
            edges++;
        end
        checkOutput("latency64", 65'(edges), 65'd64);
        checkOutput("sum64", bus64.out_sum, expSum);
        checkOutput("co64", bus64.out_co, expCo);
        bus64.out_ready = 1'b1;
        stepCycle();
        bus64.out_ready = 1'b0;
        checkOutput("in_ready64", bus64.in_ready, 1);
    endtask

    initial begin
        logic [8:0] model;
        logic [7:0] ra, rb;
        logic       rci;

        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_ci = 1'b0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_ci = 1'b0; bus1.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_ci = 1'b0; bus64.out_ready = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        repeat (3) stepCycle();
        checkOutput("rst_in_ready", bus8.in_ready, 1);
        checkOutput("rst_out_valid", bus8.out_valid, 0);
        checkOutput("rst_busy", bus8.busy, 0);
        checkOutput("rst_out_sum", bus8.out_sum, 0);
        checkOutput("rst_out_co", bus8.out_co, 0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] directed WIDTH=8 vectors");
        applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0);

        $display("[TB] backpressure with in_valid held while busy");
        applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 5, 1'b1);

        $display("[TB] reset in the middle of an operation");
        bus8.in_a = 8'hAA; bus8.in_b = 8'h55; bus8.in_ci = 1'b1;
        bus8.in_valid = 1'b1;
        stepCycle();
        bus8.in_valid = 1'b0;
        repeat (3) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_out_valid", bus8.out_valid, 0);
        checkOutput("midrst_in_ready", bus8.in_ready, 1);
        checkOutput("midrst_busy", bus8.busy, 0);
        checkOutput("midrst_out_sum", bus8.out_sum, 0);
        checkOutput("midrst_out_co", bus8.out_co, 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("midrst_stays_idle", bus8.in_ready, 1);
        applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b0);

        $display("[TB] WIDTH=1 exhaustive");
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            logic [1:0] tot;
            bits = 3'(v);
            tot  = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
            runW1(bits[2], bits[1], bits[0], tot[0], tot[1]);
        end

        $display("[TB] WIDTH=64 directed");
        runW64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
        runW64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        runW64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1);
        runW64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1);
        runW64(64'h1, 64'h2, 1'b1, 64'h4, 1'b0);
        runW64(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 64'h0000_0001_FFFF_FFFF, 1'b0);

        $display("[TB] random WIDTH=8 operations");
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) stepCycle();
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rci   = 1'($urandom_range(0, 1));
            model = 9'(ra) + 9'(rb) + 9'(rci);
            applyStimulus(ra, rb, rci, model[7:0], model[8],
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
